// File: rtl/fp_alu_dispatcher.sv
// fp_alu_dispatcher
//   Command front-end for top_fp_alu. Buffers FP requests in a FIFO, issues them one at a time
//   with the ALU start/valid_out handshake, returns tagged results on a valid/ready response
//   port and accumulates sticky IEEE flags {NV,DZ,OF,UF,NX}.
//
//   Optional feature macro: FP_DISP_TIMEOUT_EN
//     defined   -> WAIT watchdog of TIMEOUT_CYC cycles, reports via rsp_timeout
//     undefined -> WAIT is unbounded, rsp_timeout tied to 0
//
//   Ports
//     clk, rst_n                         clock, async active-low reset
//     cmd_valid/cmd_ready                command push handshake
//     cmd_op/mode/a/b/tag                command payload
//     alu_start, alu_op_code,            issue interface towards the ALU
//     alu_mode_fp, alu_op_a/b
//     alu_result, alu_flags, alu_valid   ALU completion
//     rsp_valid/rsp_ready                response handshake
//     rsp_result/flags/tag/timeout       response payload
//     sticky_flags, sticky_clr           accumulated flags and their clear
//     busy, fifo_count                   status
module fp_alu_dispatcher #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 600
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic                    cmd_mode,
    input  logic [31:0]             cmd_a,
    input  logic [31:0]             cmd_b,
    input  logic [TAG_W-1:0]        cmd_tag,
    output logic                    alu_start,
    output logic [2:0]              alu_op_code,
    output logic                    alu_mode_fp,
    output logic [31:0]             alu_op_a,
    output logic [31:0]             alu_op_b,
    input  logic [31:0]             alu_result,
    input  logic [4:0]              alu_flags,
    input  logic                    alu_valid,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [31:0]             rsp_result,
    output logic [4:0]              rsp_flags,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic                    rsp_timeout,
    output logic [4:0]              sticky_flags,
    input  logic                    sticky_clr,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int unsigned AddrW        = $clog2(DEPTH);
    localparam int unsigned EntryW       = 3 + 1 + 32 + 32 + TAG_W;
    localparam logic [AddrW:0] DepthCnt  = DEPTH[AddrW:0];
    localparam logic [31:0] QnanSingle   = 32'h7FC0_0000;
    localparam logic [31:0] QnanHalf     = 32'h0000_7E00;
    localparam logic [4:0]  FlagsNv      = 5'b10000;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC == 0) begin : g_bad_param
        $error("fp_alu_dispatcher: DEPTH must be a power of two >= 2, TIMEOUT_CYC nonzero");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

    state_e             r_state, w_state_next;
    logic [EntryW-1:0]  r_mem [DEPTH];
    logic [AddrW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AddrW:0]     r_count;
    logic [2:0]         r_iss_op;
    logic               r_iss_mode;
    logic [31:0]        r_iss_a, r_iss_b;
    logic [TAG_W-1:0]   r_iss_tag;
    logic [31:0]        r_rsp_result;
    logic [4:0]         r_rsp_flags;
    logic [4:0]         r_sticky;

    logic               w_push, w_pop, w_hs, w_alu_done, w_timeout;
    logic [EntryW-1:0]  w_wr_entry;
    logic [2:0]         w_rd_op;
    logic               w_rd_mode;
    logic [31:0]        w_rd_a, w_rd_b;
    logic [TAG_W-1:0]   w_rd_tag;

    assign w_wr_entry = {cmd_op, cmd_mode, cmd_a, cmd_b, cmd_tag};
    assign {w_rd_op, w_rd_mode, w_rd_a, w_rd_b, w_rd_tag} = r_mem[r_rd_ptr];

    assign cmd_ready  = (r_count < DepthCnt);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = (r_state == StIdle) && (r_count != '0);
    assign w_hs       = (r_state == StHold) && rsp_ready;
    assign w_alu_done = (r_state == StWait) && alu_valid;

`ifdef FP_DISP_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);

    logic [ToW-1:0] r_to_cnt;
    logic           r_rsp_timeout;

    // Counts completed WAIT cycles; fires on the last one without alu_valid.
    assign w_timeout = (r_state == StWait) && !alu_valid && (r_to_cnt == ToLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt      <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_state == StIssue) begin
                r_to_cnt <= '0;
            end else if (r_state == StWait) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_rsp_timeout <= 1'b1;
            end else if (w_hs) begin
                r_rsp_timeout <= 1'b0;
            end
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_timeout   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // FIFO storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_pop) w_state_next = w_rd_op[2] ? StHold : StIssue;
            StIssue: w_state_next = StWait;
            StWait:  if (alu_valid || w_timeout) w_state_next = StHold;
            StHold:  if (rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        alu_start = (r_state == StIssue);
        rsp_valid = (r_state == StHold);
        busy      = (r_state != StIdle) || (r_count != '0);
    end

    // Issue and response registers; the issue register also holds the ALU operands stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_op     <= '0;
            r_iss_mode   <= 1'b0;
            r_iss_a      <= '0;
            r_iss_b      <= '0;
            r_iss_tag    <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_sticky     <= '0;
        end else begin
            if (w_pop) begin
                r_iss_op   <= w_rd_op;
                r_iss_mode <= w_rd_mode;
                r_iss_a    <= w_rd_a;
                r_iss_b    <= w_rd_b;
                r_iss_tag  <= w_rd_tag;
                if (w_rd_op[2]) begin
                    r_rsp_result <= w_rd_mode ? QnanSingle : QnanHalf;
                    r_rsp_flags  <= FlagsNv;
                end
            end
            if (w_alu_done) begin
                r_rsp_result <= r_iss_mode ? alu_result : {16'h0, alu_result[15:0]};
                r_rsp_flags  <= alu_flags;
            end else if (w_timeout) begin
                r_rsp_result <= r_iss_mode ? QnanSingle : QnanHalf;
                r_rsp_flags  <= FlagsNv;
            end
            // A same-cycle clear and delivery keeps only the delivered flags.
            r_sticky <= (sticky_clr ? 5'b0 : r_sticky) | (w_hs ? r_rsp_flags : 5'b0);
        end
    end

    assign alu_op_code  = r_iss_op;
    assign alu_mode_fp  = r_iss_mode;
    assign alu_op_a     = r_iss_mode ? r_iss_a : {16'h0, r_iss_a[15:0]};
    assign alu_op_b     = r_iss_mode ? r_iss_b : {16'h0, r_iss_b[15:0]};
    assign rsp_result   = r_rsp_result;
    assign rsp_flags    = r_rsp_flags;
    assign rsp_tag      = r_iss_tag;
    assign sticky_flags = r_sticky;
    assign fifo_count   = r_count;

endmodule

// File: doc/fp_alu_dispatcher.md
Name: fp_alu_dispatcher

Overview:
Command front-end that sits directly upstream of top_fp_alu. It buffers FP operation requests in a FIFO and issues them one at a time to the ALU using its start/valid_out protocol. It returns each tagged result through a valid/ready response port and keeps IEEE sticky exception flags {NV,DZ,OF,UF,NX}.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
TAG_W, 4, width of the request tag carried from command to response
TIMEOUT_CYC, 600, WAIT-state cycle limit (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; high when count < DEPTH
cmd_op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx reserved
cmd_mode  in  1  1 = single (32-bit), 0 = half (16-bit, in [15:0])
cmd_a, cmd_b  in  32  operands
cmd_tag  in  TAG_W  request tag
alu_start  out  1  one-cycle start pulse to the ALU
alu_op_code  out  3  to ALU op_code
alu_mode_fp  out  1  to ALU mode_fp
alu_op_a, alu_op_b  out  32  to ALU operands
alu_result  in  32  ALU result
alu_flags  in  5  ALU flags {NV,DZ,OF,UF,NX}
alu_valid  in  1  ALU valid_out
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts the response
rsp_result  out  32  result; in half mode [31:16] = 0
rsp_flags  out  5  flags for this operation
rsp_tag  out  TAG_W  tag of the originating command
rsp_timeout  out  1  response was produced by the watchdog
sticky_flags  out  5  OR-accumulation of all delivered rsp_flags
sticky_clr  in  1  clear sticky_flags
busy  out  1  FSM not IDLE or FIFO not empty
fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0 except cmd_ready = 1. FIFO is emptied, FSM goes to IDLE. An in-flight operation is dropped and produces no response.
- FIFO push: a command is pushed on a rising edge with cmd_valid && cmd_ready.
- FIFO pop: happens only in IDLE with count > 0.
- Simultaneous push and pop: count is unchanged. cmd_ready depends only on count.
- FIFO pointers wrap modulo DEPTH.
- Entry latch: the popped entry (op, mode, a, b, tag) is latched into an issue register.
- Half-mode operands: when mode = 0, alu_op_a and alu_op_b drive {16'h0, x[15:0]}.
- FSM IDLE: if count > 0, pop.
  - op[2] = 1 goes to HOLD with result 0x7FC00000 (single) or 0x00007E00 (half) and flags 10000. No alu_start is issued.
  - Otherwise goes to ISSUE.
- FSM ISSUE: alu_start = 1 for exactly this cycle, then WAIT.
- Operand hold: alu_op_code, alu_mode_fp, alu_op_a and alu_op_b stay stable from ISSUE until leaving WAIT.
- FSM WAIT: on alu_valid = 1, capture alu_result (half: [31:16] forced 0) and alu_flags, then go to HOLD.
- FSM HOLD: rsp_valid = 1, and rsp_* stay stable until rsp_ready. On the rsp_valid && rsp_ready edge, go to IDLE.
- Latency, empty FIFO: command pushed at edge N, pop at N+1, alu_start high in the cycle after N+1. rsp_valid rises on the edge after the alu_valid cycle.
- Throughput: at most one operation in flight. The ALU never sees start while in WAIT or HOLD.
- Sticky update: sticky_flags <= (sticky_clr ? 0 : sticky_flags) | (handshake ? rsp_flags : 0). A same-cycle clear and delivery therefore leaves only the new flags.
- alu_valid outside WAIT is ignored.

Optional Feature:
Macro FP_DISP_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. After TIMEOUT_CYC cycles with no alu_valid, the FSM goes to HOLD with the invalid-op default result, flags 10000 and rsp_timeout = 1.
  - rsp_timeout clears when the response is accepted.
- Undefined: WAIT lasts indefinitely, no counter is synthesised, and rsp_timeout is tied to 0.

Test Plan:
- Single ADD: ALU model with 3-cycle latency; cmd op=000, mode=1, a=0x411CCCCD, b=0x4089999A, tag=5, model returns 0x4161999A / 00001. Required: exactly one alu_start pulse; rsp_result=0x4161999A, rsp_tag=5, sticky_flags=00001.
- Half DIV: cmd op=011, mode=0, a=0xABCD3C00, b=0x00000000, model returns 0x7C00 / 01000. Required: alu_op_a=0x00003C00; rsp_result=0x00007C00, rsp_flags=01000.
- Reserved op: cmd op=111, mode=0. Required: no alu_start; rsp_result=0x00007E00, rsp_flags=10000.
- Back-pressure: rsp_ready=0 with DEPTH=4 and 6 commands offered. Required: 5 accepted (1 in flight, 4 queued), cmd_ready=0, fifo_count=4. Then hold rsp_ready=1: tags return in order, count falls to 0, busy falls.
- Sticky flags: deliver flags 00001 then 00100 → sticky_flags=00101. Then sticky_clr in the same cycle as delivering 00010 → sticky_flags=00010.
- Reset mid-WAIT, then timeout: assert rst_n=0 while in WAIT → outputs return to reset values and no response appears. With FP_DISP_TIMEOUT_EN, TIMEOUT_CYC=16 and a silent ALU → rsp_valid after 16 WAIT cycles, rsp_result=0x7FC00000, rsp_timeout=1.
